// File: rtl/mips_alu_seq_if.sv
// Operand/result handshake bundle for mips_alu_seq: valid/ready in, valid/ready out.
// master = upstream decode/regread plus downstream writeback; slave = the ALU.
interface mips_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_hi;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_ctl, a, b, out_ready,
    input  in_ready, out_valid, alu_out, alu_hi, zero, overflow
  );

  modport slave (
    input  in_valid, alu_ctl, a, b, out_ready,
    output in_ready, out_valid, alu_out, alu_hi, zero, overflow
  );
endinterface

// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU with shifts and an iterative shift-add unsigned multiply.
// Define ALU_OVERFLOW_EN to build signed ADD/SUB overflow detection; otherwise overflow is 0.
module mips_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  mips_alu_seq_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_MULT = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_is_mult;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic [WIDTH-1:0]        w_res;

  logic [2*WIDTH-1:0]      r_mcand;
  logic [WIDTH-1:0]        r_mplier;
  logic [2*WIDTH-1:0]      r_prod;
  logic [2*WIDTH-1:0]      w_prod_nxt;
  logic [SHW-1:0]          r_cnt;
  logic                    w_mul_last;

  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_alu_out;
  logic [WIDTH-1:0]        r_alu_hi;
  logic                    r_zero;

  assign bus.in_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_is_mult    = (bus.alu_ctl == OP_MULT);

  assign w_a_s  = $signed(bus.a);
  assign w_b_s  = $signed(bus.b);
  assign w_sum  = bus.a + bus.b;
  assign w_diff = bus.a - bus.b;

  always_comb begin
    w_res = '0;
    case (bus.alu_ctl)
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_diff;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_NOR:  w_res = ~(bus.a | bus.b);
      OP_SLL:  w_res = bus.a << bus.b[SHW-1:0];
      OP_SRL:  w_res = bus.a >> bus.b[SHW-1:0];
      default: w_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic w_res_ovf;
  logic r_ovf;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  always_comb begin
    w_res_ovf = 1'b0;
    case (bus.alu_ctl)
      OP_ADD:  w_res_ovf = add_ovf(w_a_s, w_b_s, $signed(w_sum));
      OP_SUB:  w_res_ovf = sub_ovf(w_a_s, w_b_s, $signed(w_diff));
      default: w_res_ovf = 1'b0;
    endcase
  end

  // MULT clears overflow at accept so its later result carries 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= w_is_mult ? 1'b0 : w_res_ovf;
    end
  end

  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

  // Stage: control state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mult ? S_MUL : S_HOLD;
      S_MUL:  if (w_mul_last) w_state_nxt = S_HOLD;
      S_HOLD: if (bus.out_ready) begin
                if (w_accept) w_state_nxt = w_is_mult ? S_MUL : S_HOLD;
                else          w_state_nxt = S_IDLE;
              end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage: shift-add multiplier datapath, one multiplier bit per cycle
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_prod   <= '0;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Stage: result registers; data is left untouched when a result drains
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_alu_hi    <= '0;
      r_zero      <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_is_mult) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b1;
        r_alu_out   <= w_res;
        r_alu_hi    <= '0;
        r_zero      <= (w_res == '0);
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + SHW'(1);
      if (w_mul_last) begin
        r_out_valid <= 1'b1;
        r_alu_out   <= w_prod_nxt[WIDTH-1:0];
        r_alu_hi    <= w_prod_nxt[2*WIDTH-1:WIDTH];
        r_zero      <= (w_prod_nxt[WIDTH-1:0] == '0);
      end
    end else if ((r_state == S_HOLD) && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.alu_out   = r_alu_out;
  assign bus.alu_hi    = r_alu_hi;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed + scoreboard bench for mips_alu_seq at WIDTH=8; honours ALU_OVERFLOW_EN.
module tb_mips_alu_seq;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       z;
    logic       ov;
  } exp_t;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t mon_e;

  mips_alu_seq_if #(.WIDTH(8)) bus ();

  mips_alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] lo, input logic [7:0] hi,
                              input logic z, input logic ov);
    exp_t e;
    e.lo = lo; e.hi = hi; e.z = z; e.ov = ov;
    return e;
  endfunction

  // Independent reference: integer arithmetic, overflow from range checks.
  function automatic exp_t ref_alu(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sx, sy, r;
    bit   ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = 0;
    ov = 1'b0;
    e  = '0;
    case (c)
      4'b0000: r = int'(x & y);
      4'b0001: r = int'(x | y);
      4'b0010: begin r = int'(x) + int'(y); ov = (sx + sy > 127) || (sx + sy < -128); end
      4'b0110: begin r = int'(x) - int'(y); ov = (sx - sy > 127) || (sx - sy < -128); end
      4'b0111: r = (sx < sy) ? 1 : 0;
      4'b1100: r = int'(~(x | y));
      4'b0011: r = int'(x) << y[2:0];
      4'b0100: r = int'(x) >> y[2:0];
      4'b1000: begin r = int'(x) * int'(y); e.hi = r[15:8]; end
      default: r = 0;
    endcase
    e.lo = r[7:0];
    e.z  = (e.lo == 8'h00);
    e.ov = OVF_ON & ov;
    return e;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y, input exp_t e);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("in_ready_timeout", 16'd0, 16'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = c;
    bus.a        = x;
    bus.b        = y;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: a result transfers at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 16'd1, 16'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_lo",   16'(bus.alu_out),  16'(mon_e.lo));
        chk("sb_hi",   16'(bus.alu_hi),   16'(mon_e.hi));
        chk("sb_zero", 16'(bus.zero),     16'(mon_e.z));
        chk("sb_ovf",  16'(bus.overflow), 16'(mon_e.ov));
      end
    end
  end

  initial begin
    logic [3:0] ops [10];
    int         hits;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1100, 4'b0011, 4'b0100, 4'b1000, 4'b0101};

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_ctl   = 4'b0010;
    bus.a         = 8'h11;
    bus.b         = 8'h22;
    bus.out_ready = 1'b1;
    cycles(2);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_alu_out",   16'(bus.alu_out),   16'd0);
    chk("rst_alu_hi",    16'(bus.alu_hi),    16'd0);
    chk("rst_zero",      16'(bus.zero),      16'd0);
    chk("rst_ovf",       16'(bus.overflow),  16'd0);
    chk("rst_in_ready",  16'(bus.in_ready),  16'd1);

    issue(4'b0000, 8'h01, 8'h03, mk(8'h01, 8'h00, 1'b0, 1'b0));
    chk("and_latency_valid", 16'(bus.out_valid), 16'd1);
    chk("and_hi",            16'(bus.alu_hi),    16'd0);

    issue(4'b0110, 8'h00, 8'h01, mk(8'hFF, 8'h00, 1'b0, 1'b0));
    issue(4'b0111, 8'h80, 8'h01, mk(8'h01, 8'h00, 1'b0, 1'b0));
    issue(4'b1100, 8'h00, 8'hFF, mk(8'h00, 8'h00, 1'b1, 1'b0));
    chk("nor_zero", 16'(bus.zero), 16'd1);

    issue(4'b0010, 8'h7F, 8'h01, mk(8'h80, 8'h00, 1'b0, OVF_ON));
    chk("add_ovf", 16'(bus.overflow), 16'(OVF_ON));
    issue(4'b0011, 8'h81, 8'h03, mk(8'h08, 8'h00, 1'b0, 1'b0));
    issue(4'b0100, 8'h81, 8'h09, mk(8'h40, 8'h00, 1'b0, 1'b0));
    cycles(2);

    issue(4'b1000, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 1'b0, 1'b0));
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", 16'(hits), 16'd0);
    chk("mul_valid_at_8", 16'(bus.out_valid), 16'd1);
    chk("mul_hi_direct",  16'(bus.alu_hi),    16'h00FE);
    cycles(2);

    bus.out_ready = 1'b0;
    issue(4'b0001, 8'h5A, 8'h0F, mk(8'h5F, 8'h00, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.alu_ctl  = 4'b0010;
    bus.a        = 8'h02;
    bus.b        = 8'h03;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready",  16'(bus.in_ready),  16'd0);
      chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_alu_out",   16'(bus.alu_out),   16'h005F);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    sbq.push_back(mk(8'h05, 8'h00, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_out_valid", 16'(bus.out_valid), 16'd1);
    chk("b2b_alu_out",   16'(bus.alu_out),   16'h0005);
    issue(4'b1111, 8'h12, 8'h34, mk(8'h00, 8'h00, 1'b1, 1'b0));
    chk("illegal_zero", 16'(bus.zero), 16'd1);
    cycles(2);

    issue(4'b1000, 8'hAB, 8'hCD, mk(8'h00, 8'h00, 1'b0, 1'b0));
    void'(sbq.pop_back());
    cycles(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_out_valid", 16'(bus.out_valid), 16'd0);
    chk("abort_in_ready",  16'(bus.in_ready),  16'd1);
    chk("abort_alu_out",   16'(bus.alu_out),   16'd0);
    chk("abort_alu_hi",    16'(bus.alu_hi),    16'd0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    chk("abort_no_late_result", 16'(hits), 16'd0);
    issue(4'b0000, 8'h0F, 8'h3C, mk(8'h0C, 8'h00, 1'b0, 1'b0));
    chk("after_abort_hi", 16'(bus.alu_hi), 16'd0);
    cycles(2);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      logic [7:0] x, y;
      c = ops[$urandom_range(0, 9)];
      x = 8'($urandom);
      y = 8'($urandom);
      issue(c, x, y, ref_alu(c, x, y));
    end

    hits = 0;
    while (sbq.size() != 0 && hits < 40) begin
      @(posedge clk); #1;
      hits++;
    end
    chk("sb_drained", 16'(sbq.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational MIPS ALU. It keeps the same ALU control encoding and adds shifts and an iterative unsigned multiply. Operands are accepted through a valid/ready handshake, and results leave through a registered valid/ready output stage. It sits between the decode/register-read stage and writeback in the multi-cycle datapath.

Parameters:
WIDTH, 8, operand/result width; power of two, minimum 4
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept this cycle
alu_ctl  in  4  operation code
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result registers valid
out_ready  in  1  downstream consumes result
alu_out  out  WIDTH  result (low half for MULT)
alu_hi  out  WIDTH  high half of product; 0 for other ops
zero  out  1  alu_out == 0
overflow  out  1  signed overflow (see Optional Feature)

Behaviour:
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a-b)
  - 0111 SLT: 1 if signed a < signed b, else 0
  - 1100 NOR
  - 0011 SLL: a << b[SHW-1:0]
  - 0100 SRL: logical, a >> b[SHW-1:0]
  - 1000 MULT: unsigned a*b, 2*WIDTH bits, split across {alu_hi, alu_out}
  - any other code: alu_out=0, alu_hi=0, zero=1, overflow=0
- ADD/SUB wrap modulo 2^WIDTH.
- States and transitions:
  - IDLE → HOLD on accept of a non-MULT op.
  - IDLE → MUL on accept of MULT.
  - MUL → HOLD after WIDTH iterations.
  - HOLD → IDLE on out_ready when no new accept occurs that cycle.
  - HOLD → HOLD or MUL on simultaneous drain and new accept.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Combinational; never depends on in_valid.
- Accept = in_valid & in_ready at a rising edge E.
- Non-MULT latency: alu_out, alu_hi, zero, overflow and out_valid are all loaded at E and visible after E (1 cycle).
- MULT: a and b are latched at E. Shift-add runs one bit per cycle at edges E+1..E+WIDTH, and the result plus out_valid are loaded at E+WIDTH. During MUL, out_valid=0 and in_ready=0.
- HOLD with out_ready=0: all outputs held stable and in_ready=0.
- HOLD with out_ready=1 and a new accept in the same cycle:
  - Non-MULT: new result loaded, out_valid stays 1 (back-to-back, one result per cycle).
  - MULT: out_valid drops to 0 until MUL completes.
- HOLD with out_ready=1 and no accept: out_valid=0 next cycle. Data registers retain their last value.
- zero is computed from the registered alu_out only (ignores alu_hi).
- Reset (any state, including mid-MULT) on the next edge:
  - state=IDLE, out_valid=0
  - alu_out=0, alu_hi=0, zero=0, overflow=0
  - iteration counter=0
  - any in-flight MULT is discarded with no partial result.
- in_valid asserted during reset is ignored.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined: overflow is registered with the result.
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
  - All other ops: 0.
- When undefined: overflow is tied to 0 and no detection logic is built.
- The port exists in both cases.

Test Plan:
1. WIDTH=8, reset 2 cycles then AND a=0x01 b=0x03 → after 1 edge: out_valid=1, alu_out=0x01, zero=0, alu_hi=0.
2. SUB a=0x00 b=0x01 → alu_out=0xFF, overflow=0. Then SLT a=0x80 b=0x01 → alu_out=0x01. Then NOR a=0x00 b=0xFF → alu_out=0x00, zero=1.
3. ADD a=0x7F b=0x01 → alu_out=0x80, overflow=1 with ALU_OVERFLOW_EN and 0 without. SLL a=0x81 b=0x03 → 0x08. SRL a=0x81 b=0x09 → 0x40 (shift amount 1).
4. MULT a=0xFF b=0xFF → in_ready=0 for 8 cycles; out_valid rises exactly 8 edges after accept; alu_hi=0xFE, alu_out=0x01.
5. Backpressure: OR result pending, out_ready=0 for 3 cycles while in_valid=1 → outputs stable, in_ready=0. Then out_ready=1 with ADD 0x02+0x03 presented → next cycle alu_out=0x05, out_valid stays 1. Illegal op 1111 → alu_out=0, zero=1.
6. Reset asserted 3 cycles into MULT → next cycle out_valid=0, in_ready=1, alu_out=0. A following AND 0x0F&0x3C returns 0x0C with no trace of the aborted product.
